// File: rtl/requant_pkg.sv
// rtl/requant_pkg.sv - shared formats, id width helper and index type for requant_arbiter
package requant_pkg;

  localparam int N_REQ_DEF         = 4;
  localparam int DIN_WIDTH_DEF     = 32;  // Q8.24
  localparam int DIN_FRAC_DEF      = 24;
  localparam int DOUT_WIDTH_DEF    = 16;  // Q4.12
  localparam int DOUT_FRAC_DEF     = 12;
  localparam int OVR_CNT_WIDTH_DEF = 8;

  function automatic int id_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  typedef logic [id_width(N_REQ_DEF)-1:0] req_idx_t;

endpackage

// File: rtl/requant_arbiter_if.sv
// rtl/requant_arbiter_if.sv - requester and output handshake bundle for requant_arbiter
interface requant_arbiter_if
  import requant_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
  parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
  parameter int ID_W       = id_width(N_REQ_DEF)
) ();

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*DIN_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]           req_ovr;
  logic [N_REQ-1:0]           req_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [DOUT_WIDTH-1:0]      out_data;
  logic                       out_ovr;
  logic [ID_W-1:0]            out_id;

  modport slave (
    input  req_valid, req_data, req_ovr, out_ready,
    output req_ready, out_valid, out_data, out_ovr, out_id
  );

  modport master (
    output req_valid, req_data, req_ovr, out_ready,
    input  req_ready, out_valid, out_data, out_ovr, out_id
  );

endinterface

// File: rtl/fixed_point_converter.sv
// rtl/fixed_point_converter.sv - truncating signed fixed-point format converter with overflow flag
module fixed_point_converter #(
  parameter int DIN_WIDTH  = 32,
  parameter int DIN_FRAC   = 24,
  parameter int DOUT_WIDTH = 16,
  parameter int DOUT_FRAC  = 12
) (
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  i_ovr,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  o_ovr
);

  localparam int SH_L = (DOUT_FRAC > DIN_FRAC) ? DOUT_FRAC - DIN_FRAC : 0;
  localparam int SH_R = (DIN_FRAC > DOUT_FRAC) ? DIN_FRAC - DOUT_FRAC : 0;
  localparam int AW   = DIN_WIDTH + SH_L - SH_R;

  logic [AW-1:0] aligned;

  // Binary point alignment: zero-pad or drop fractional LSBs.
  generate
    if (SH_L > 0) begin : g_pad
      assign aligned = {din, {SH_L{1'b0}}};
    end else if (SH_R > 0) begin : g_drop
      logic unused_lsb;
      assign aligned    = din[DIN_WIDTH-1:SH_R];
      assign unused_lsb = ^din[SH_R-1:0];
    end else begin : g_same
      assign aligned = din;
    end

    // Integer part: drop upper bits or sign-extend.
    if (AW > DOUT_WIDTH) begin : g_trunc
      logic unused_msb;
      assign dout       = aligned[DOUT_WIDTH-1:0];
      assign unused_msb = ^aligned[AW-1:DOUT_WIDTH];
    end else if (AW == DOUT_WIDTH) begin : g_exact
      assign dout = aligned;
    end else begin : g_sext
      assign dout = {{(DOUT_WIDTH-AW){aligned[AW-1]}}, aligned};
    end
  endgenerate

  assign o_ovr = i_ovr | (dout[DOUT_WIDTH-1] ^ din[DIN_WIDTH-1]);

endmodule

// File: rtl/requant_arbiter.sv
// rtl/requant_arbiter.sv - round-robin arbiter sharing one requantizer, with overflow status
module requant_arbiter
  import requant_pkg::*;
#(
  parameter int N_REQ         = N_REQ_DEF,
  parameter int DIN_WIDTH     = DIN_WIDTH_DEF,
  parameter int DIN_FRAC      = DIN_FRAC_DEF,
  parameter int DOUT_WIDTH    = DOUT_WIDTH_DEF,
  parameter int DOUT_FRAC     = DOUT_FRAC_DEF,
  parameter int OVR_CNT_WIDTH = OVR_CNT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  requant_arbiter_if.slave         bus,
  input  logic                     ovr_clear,
  output logic [N_REQ-1:0]         ovr_sticky,
  output logic [OVR_CNT_WIDTH-1:0] ovr_count
);

  localparam int ID_W = id_width(N_REQ);
  localparam logic [ID_W-1:0]          LAST_INIT = ID_W'(N_REQ - 1);
  localparam logic [OVR_CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [ID_W-1:0]       last;
  logic [ID_W-1:0]       win;
  logic                  found;
  logic                  accept;
  logic                  fire;
  logic [N_REQ-1:0]      win_onehot;
  logic [DIN_WIDTH-1:0]  sel_data;
  logic                  sel_ovr;
  logic [DOUT_WIDTH-1:0] conv_data;
  logic                  conv_ovr;

  logic                  out_valid_q;
  logic [DOUT_WIDTH-1:0] out_data_q;
  logic                  out_ovr_q;
  logic [ID_W-1:0]       out_id_q;

  assign accept = !out_valid_q || bus.out_ready;
  assign fire   = accept && found;

  // Search starts just after the last winner so every requester waits at most N_REQ-1 grants.
  always_comb begin : rr_search
    int idx;
    win   = last;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req_valid[idx]) begin
        win   = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
  end

  assign bus.req_ready = (fire && !rst) ? win_onehot : '0;

  assign sel_data = bus.req_data[int'(win)*DIN_WIDTH +: DIN_WIDTH];
  assign sel_ovr  = bus.req_ovr[win];

  fixed_point_converter #(
    .DIN_WIDTH  (DIN_WIDTH),
    .DIN_FRAC   (DIN_FRAC),
    .DOUT_WIDTH (DOUT_WIDTH),
    .DOUT_FRAC  (DOUT_FRAC)
  ) u_conv (
    .din   (sel_data),
    .i_ovr (sel_ovr),
    .dout  (conv_data),
    .o_ovr (conv_ovr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovr_q   <= 1'b0;
      out_id_q    <= '0;
      last        <= LAST_INIT;
    end else if (accept) begin
      if (found) begin
        out_valid_q <= 1'b1;
        out_data_q  <= conv_data;
        out_ovr_q   <= conv_ovr;
        out_id_q    <= win;
        last        <= win;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // A fresh overflow event takes precedence over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_sticky <= '0;
      ovr_count  <= '0;
    end else if (fire && conv_ovr) begin
      if (ovr_clear) begin
        ovr_sticky <= win_onehot;
        ovr_count  <= OVR_CNT_WIDTH'(1);
      end else begin
        ovr_sticky <= ovr_sticky | win_onehot;
        ovr_count  <= (ovr_count == CNT_MAX) ? ovr_count : ovr_count + 1'b1;
      end
    end else if (ovr_clear) begin
      ovr_sticky <= '0;
      ovr_count  <= '0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovr   = out_ovr_q;
  assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_requant_arbiter.sv
// tb/tb_requant_arbiter.sv - self-checking bench for requant_arbiter
module tb_requant_arbiter;
  import requant_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ovr_clear = 1'b0;
  logic [N-1:0]  ovr_sticky;
  logic [CW-1:0] ovr_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  requant_arbiter_if #(.N_REQ(N), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .ID_W(2)) bus ();

  requant_arbiter #(
    .N_REQ(N), .DIN_WIDTH(DW), .DIN_FRAC(24),
    .DOUT_WIDTH(OW), .DOUT_FRAC(12), .OVR_CNT_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ovr_clear  (ovr_clear),
    .ovr_sticky (ovr_sticky),
    .ovr_count  (ovr_count)
  );

  // Reference model: Q8.24 -> Q4.12 is value/2^12 kept modulo 2^16.
  function automatic logic [15:0] conv(input logic [31:0] d);
    logic signed [31:0] s;
    s = d;
    s = s >>> 12;
    return s[15:0];
  endfunction

  function automatic logic conv_ovr(input logic [31:0] d, input logic up);
    logic [15:0] r;
    r = conv(d);
    return up | (r[15] != d[31]);
  endfunction

  function automatic int pick(input int lst, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(lst + k) % N]) return (lst + k) % N;
    end
    return -1;
  endfunction

  logic        mv = 1'b0;
  logic [15:0] md = '0;
  logic        mo = 1'b0;
  int          mid = 0;
  int          mlast = N - 1;
  logic [N-1:0] ms = '0;
  int          mc = 0;

  always @(posedge clk) begin : model_upd
    int w;
    logic acc;
    logic [31:0] d;
    logic o;
    if (rst) begin
      mv <= 1'b0; md <= '0; mo <= 1'b0; mid <= 0; mlast <= N - 1; ms <= '0; mc <= 0;
    end else begin
      w   = pick(mlast, bus.req_valid);
      acc = !mv || bus.out_ready;
      if (acc && w >= 0) begin
        d = bus.req_data[w*DW +: DW];
        o = conv_ovr(d, bus.req_ovr[w]);
        mv <= 1'b1; md <= conv(d); mo <= o; mid <= w; mlast <= w;
        if (o && ovr_clear) begin
          ms <= N'(1 << w); mc <= 1;
        end else if (o) begin
          ms <= ms | N'(1 << w); mc <= (mc >= 255) ? 255 : mc + 1;
        end else if (ovr_clear) begin
          ms <= '0; mc <= 0;
        end
      end else begin
        if (acc) mv <= 1'b0;
        if (ovr_clear) begin
          ms <= '0; mc <= 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    int w;
    logic [N-1:0] er;
    w  = pick(mlast, bus.req_valid);
    er = '0;
    if (!rst && (!mv || bus.out_ready) && w >= 0) er = N'(1 << w);
    check("m_req_ready", 32'(bus.req_ready), 32'(er));
    check("m_out_valid", 32'(bus.out_valid), 32'(mv));
    check("m_out_data",  32'(bus.out_data),  32'(md));
    check("m_out_ovr",   32'(bus.out_ovr),   32'(mo));
    check("m_out_id",    32'(bus.out_id),    32'(mid));
    check("m_sticky",    32'(ovr_sticky),    32'(ms));
    check("m_count",     32'(ovr_count),     32'(mc));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_word(input int i, input logic [31:0] d);
    bus.req_data[i*DW +: DW] = d;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_ovr   = '0;
    bus.out_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      check("idle_req_ready", 32'(bus.req_ready), 32'd0);
    end
    check("idle_sticky", 32'(ovr_sticky), 32'd0);
    check("idle_count",  32'(ovr_count),  32'd0);

    set_word(2, 32'h0180_0000);
    bus.req_valid = 4'b0100;
    step();
    check("pos_data", 32'(bus.out_data), 32'h1800);
    check("pos_id",   32'(bus.out_id),   32'd2);
    check("pos_ovr",  32'(bus.out_ovr),  32'd0);
    set_word(2, 32'hFE80_0000);
    step();
    check("neg_data", 32'(bus.out_data), 32'hE800);
    check("neg_ovr",  32'(bus.out_ovr),  32'd0);
    bus.req_valid = '0;
    step();
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_word(i, 32'(i) << 24);
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      step();
      check("rr_id",   32'(bus.out_id),   32'(c % 4));
      check("rr_data", 32'(bus.out_data), 32'(c % 4) << 12);
    end

    bus.req_valid = 4'b0010;
    set_word(1, 32'h0800_0000);
    step();
    check("ovf_data",   32'(bus.out_data), 32'h8000);
    check("ovf_ovr",    32'(bus.out_ovr),  32'd1);
    check("ovf_sticky", 32'(ovr_sticky),   32'b0010);
    check("ovf_count",  32'(ovr_count),    32'd1);
    bus.req_valid = 4'b1000;
    set_word(3, 32'h0800_0000);
    ovr_clear = 1'b1;
    step();
    ovr_clear = 1'b0;
    check("clr_sticky", 32'(ovr_sticky), 32'b1000);
    check("clr_count",  32'(ovr_count),  32'd1);

    bus.req_valid = 4'b0001;
    set_word(0, 32'h0010_0000);
    bus.req_ovr = 4'b0001;
    step();
    bus.req_ovr = '0;
    check("up_data",   32'(bus.out_data), 32'h0100);
    check("up_ovr",    32'(bus.out_ovr),  32'd1);
    check("up_sticky", 32'(ovr_sticky),   32'b1001);
    check("up_count",  32'(ovr_count),    32'd2);

    for (int i = 0; i < N; i++) set_word(i, 32'(i) << 24);
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("bp_data",  32'(bus.out_data),  32'h0100);
      check("bp_id",    32'(bus.out_id),    32'd0);
      check("bp_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    for (int c = 1; c < 4; c++) begin
      step();
      check("rel_id",   32'(bus.out_id),   32'(c));
      check("rel_data", 32'(bus.out_data), 32'(c) << 12);
    end

    bus.out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count", 32'(ovr_count),     32'd0);
    bus.out_ready = 1'b1;
    step();
    check("reserve_valid", 32'(bus.out_valid), 32'd1);
    check("reserve_id",    32'(bus.out_id),    32'd0);

    bus.req_valid = 4'b0010;
    set_word(1, 32'h0800_0000);
    repeat (255) step();
    check("sat_255", 32'(ovr_count), 32'd255);
    repeat (45) step();
    check("sat_hold",   32'(ovr_count),  32'd255);
    check("sat_sticky", 32'(ovr_sticky), 32'b0010);

    bus.req_valid = '0;
    ovr_clear = 1'b1;
    step();
    ovr_clear = 1'b0;
    check("clear_sticky", 32'(ovr_sticky), 32'd0);
    check("clear_count",  32'(ovr_count),  32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/requant_arbiter.md
# requant_arbiter

Shares one `fixed_point_converter` between `N_REQ` requesters in the adaptive filter datapath, such as the filter output, the error term and the weight-update products. Requesters present wide accumulator words with valid/ready handshakes. The block grants them round-robin, requantizes the granted word to the narrow output format by truncation, and registers the result with its requester ID. It also keeps per-requester sticky overflow flags and a saturating overflow event counter for the filter's status registers.

## Interface
- `N_REQ`, 4, number of requesters (≥2)
- `DIN_WIDTH`, 32, requester word width
- `DIN_FRAC`, 24, requester fractional bits
- `DOUT_WIDTH`, 16, output word width
- `DOUT_FRAC`, 12, output fractional bits
- `OVR_CNT_WIDTH`, 8, overflow counter width
- `clk`  in  1  sole clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  N_REQ  requester i has a word
- `req_data`  in  N_REQ*DIN_WIDTH  word i at bits [i*DIN_WIDTH +: DIN_WIDTH], signed fixed point
- `req_ovr`  in  N_REQ  upstream overflow flag accompanying word i
- `req_ready`  out  N_REQ  one-hot-or-zero grant; transfer when valid&ready
- `out_valid`  out  1  output register holds a result
- `out_ready`  in  1  downstream accepts
- `out_data`  out  DOUT_WIDTH  requantized word
- `out_ovr`  out  1  converter overflow (sign mismatch, or upstream flag)
- `out_id`  out  ID_W  requester index, ID_W = max(1, $clog2(N_REQ))
- `ovr_sticky`  out  N_REQ  bit i set once any transfer from requester i overflowed
- `ovr_count`  out  OVR_CNT_WIDTH  total overflowed transfers, saturating
- `ovr_clear`  in  1  one-cycle pulse clearing sticky flags and counter

## Operation
- `accept = !out_valid || out_ready`: the output register can load this cycle.
- Arbitration uses a pointer `last` holding the index of the last granted requester.
  - The search starts at `last+1` modulo N_REQ and wraps around.
  - The first index with `req_valid` set is the winner.
- `req_ready[w] = accept` for the winner; all other bits are 0. `req_ready` is combinational from `req_valid`, `out_valid` and `out_ready`.
- On transfer (`accept` and any valid):
  - `out_data` loads the converter output for `req_data[w]`.
  - `out_ovr` loads the converter overflow for `req_data[w]`, with `req_ovr[w]` as its upstream overflow input.
  - `out_id` loads w, `out_valid` goes to 1 and `last` becomes w.
- If `accept` is set and no requester is valid: `out_valid` goes to 0, `last` is unchanged and the data registers hold their value.
- If `out_valid && !out_ready`: `out_data`, `out_ovr` and `out_id` hold stable and all `req_ready` are 0.
- Conversion is truncation only, with no rounding and no saturation.
  - Integer part is sign-extended or has its upper bits dropped.
  - Fractional part is zero-padded or has its lower bits dropped.
  - Overflow means the output MSB differs from the input MSB.
- Status counters:
  - On a transfer whose converter overflow is 1: `ovr_sticky[w]` is set to 1 and `ovr_count` increments, saturating at all-ones.
  - `ovr_clear` zeroes `ovr_sticky` and `ovr_count`.
  - If a transfer with overflow coincides with `ovr_clear`, the new event wins: afterwards `ovr_sticky` is exactly bit w and `ovr_count` is 1.

## Timing
- Latency: request transfer at edge k gives `out_valid` and data visible after edge k.
- Throughput: one word per cycle while `out_ready` stays high. Fairness: each continuously valid requester is granted at least once every N_REQ transfers.
- Values after reset:
  - `out_valid` 0, `out_data` 0, `out_ovr` 0, `out_id` 0.
  - `ovr_sticky` 0, `ovr_count` 0.
  - `last` = N_REQ-1, so requester 0 has first priority.
- While `rst` is high, `req_ready` is 0.
- Reset mid-transfer drops the held output word. Requesters keep `req_valid` asserted and are re-served after reset.
- Requesters must hold `req_data` stable while valid and not ready. Requester order is not guaranteed beyond round-robin.

## Structure
- Package `requant_pkg`:
  - `ID_W` computation function.
  - Default format localparams: Q8.24 in, Q4.12 out.
  - `req_idx_t` typedef.
- One sub-module instance: `fixed_point_converter`.
  - Fed by a combinational mux on the winner index, including `req_ovr[w]` as its upstream overflow input.
  - Its `dout` and `o_ovr` feed the output register.
  - A single shared instance is the point of the block.
- The arbiter (pointer plus priority search) is local logic, not a separate module.

## Test plan
- Reset, all `req_valid` 0, `out_ready` 1 for 5 cycles: `out_valid` and `req_ready` stay 0, `ovr_sticky`=0, `ovr_count`=0.
- Single requester 2 sends 0x01800000 (1.5): next cycle `out_data`=0x1800, `out_id`=2, `out_ovr`=0. Requester 2 sends 0xFE800000 (−1.5): `out_data`=0xE800.
- All four requesters valid continuously, `out_ready`=1: grants go 0,1,2,3,0,… with one output per cycle.
- Requester 1 sends 0x08000000 (8.0): `out_data`=0x8000, `out_ovr`=1, `ovr_sticky`=0b0010, `ovr_count`=1. Next transfer asserts `ovr_clear` together with an overflowing word from requester 3: `ovr_sticky`=0b1000, `ovr_count`=1.
- `out_ready` held low for 4 cycles with requesters valid: output fields stable and `req_ready`=0 throughout. On release, one transfer per cycle resumes, starting at `last+1`.
- 300 overflowing transfers with 8-bit counter: `ovr_count` saturates at 255, with no wrap.
